cp0_unit: RTL and testbench
===========================

CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 rd_data  output  64  combinational read of the CP0 register selected by regnum/sel.
REQ-005 epc  output  64  current EPC register contents.
REQ-006 taken_handler  output  1  combinational; exception or interrupt taken this cycle.
REQ-007 wr_data  input  64  MTC0 write data.
REQ-008 regnum  input  5  CP0 register number.
REQ-009 sel  input  3  CP0 select field.
REQ-010 next_pc  input  64  PC saved into EPC on a taken event.
REQ-011 mtc0  input  1  write enable for the selected register.
REQ-012 eret  input  1  return from exception.
REQ-013 interrupt_sources  input  8  level-sensitive hardware interrupt lines.
REQ-014 overflow, reserved_inst, syscall, break_exc  inputs  1 each  synchronous exception requests.

Function
REQ-015 Only sel=0 SHALL be implemented; a nonzero sel SHALL read 0 and ignore writes.
REQ-016 Status (reg 12) SHALL hold IE at bit0, EXL at bit1 and IM at [15:8]; all other bits SHALL read 0.
REQ-017 Cause (reg 13) SHALL hold ExcCode at [6:2] and IP at [15:8]; all other bits SHALL read 0.
REQ-018 EPC (reg 14) SHALL be a full 64-bit register.
REQ-019 Unimplemented regnum values SHALL read 0; writes to them SHALL be ignored.
REQ-020 Cause.IP SHALL be loaded from interrupt_sources on every clock edge; Cause SHALL NOT be writable by MTC0.
REQ-021 int_req SHALL equal |(interrupt_sources & Status.IM) & IE & ~EXL, computed combinationally from the live inputs.
REQ-022 exc_req SHALL equal the OR of overflow, reserved_inst, syscall and break_exc.
REQ-023 taken_handler SHALL equal exc_req | int_req.
REQ-024 ExcCode priority SHALL be reserved_inst=10, then syscall=8, then break=9, then overflow=12, then interrupt=0.
REQ-025 On a taken event, the next edge SHALL set EXL=1 and load ExcCode.
REQ-026 On a taken event with EXL=0, the next edge SHALL also load EPC<=next_pc; when EXL=1, EPC SHALL be kept.
REQ-027 On eret without a taken event, the next edge SHALL clear EXL.
REQ-028 A taken event in the same cycle as eret or mtc0 SHALL take precedence for EXL and EPC; mtc0 to IE/IM SHALL still apply.
REQ-029 A write to Status or EPC SHALL take effect at the next edge; rd_data SHALL show the old value in the write cycle.

Reset
REQ-030 While reset is high, Status, Cause and EPC SHALL be 0.
REQ-031 With all registers 0, rd_data and epc SHALL read 0 and taken_handler SHALL be 0 unless an exception input is high.
REQ-032 Reset asserted mid-cycle SHALL cancel any pending update.

Configuration
REQ-033 Under CP0_TIMER_EN, the block SHALL add Count (reg 9), incremented every cycle, and Compare (reg 11); both SHALL be 32-bit, zero-extended on read, and reset to 0.
REQ-034 Under CP0_TIMER_EN, Count==Compare SHALL set a sticky timer flag ORed into interrupt_sources[7]; a write to Compare SHALL clear the flag.
REQ-035 Without CP0_TIMER_EN, regs 9 and 11 SHALL read 0 and no timer logic SHALL exist.

Structure
REQ-036 Package cp0_pkg SHALL hold the register numbers (9, 11, 12, 13, 14), the Status/Cause bit positions and the ExcCode constants.
REQ-037 Each CP0 register SHALL be an instance of a single sub-module cp0_reg: a resettable register with enable and width parameter.

Verification
REQ-038 Reset, then read regs 12/13/14 -> all read 0; taken_handler=0.
REQ-039 mtc0 reg12 = 0x0000_FF01, then interrupt_sources=0x04 with next_pc=0x400 -> taken_handler=1; after the edge EPC=0x400, EXL=1, Cause=0x0000_0400.
REQ-040 With EXL=1, pulse eret -> EXL=0; the interrupt, still asserted, re-takes next cycle.
REQ-041 reserved_inst and overflow together with next_pc=0x1000 -> ExcCode=10, EPC=0x1000.
REQ-042 Exception while EXL=1 with next_pc=0x2000 -> EPC unchanged, ExcCode updated.
REQ-043 Under CP0_TIMER_EN, Compare=5 after reset -> timer flag sets when Count reaches 5; with IM[7]=1 and IE=1 -> taken_handler=1.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause field positions,
// exception codes, register payload structs and read-format helpers.
package cp0_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned IRQ_W   = 8;
  localparam int unsigned EXC_W   = 5;
  localparam int unsigned TIMER_W = 32;

  localparam logic [REG_W-1:0] REG_COUNT   = 5'd9;
  localparam logic [REG_W-1:0] REG_COMPARE = 5'd11;
  localparam logic [REG_W-1:0] REG_STATUS  = 5'd12;
  localparam logic [REG_W-1:0] REG_CAUSE   = 5'd13;
  localparam logic [REG_W-1:0] REG_EPC     = 5'd14;

  localparam int unsigned STATUS_IE_BIT  = 0;
  localparam int unsigned STATUS_EXL_BIT = 1;
  localparam int unsigned STATUS_IM_LSB  = 8;
  localparam int unsigned CAUSE_EXC_LSB  = 2;
  localparam int unsigned CAUSE_IP_LSB   = 8;

  localparam logic [EXC_W-1:0] EXC_INT = 5'd0;
  localparam logic [EXC_W-1:0] EXC_SYS = 5'd8;
  localparam logic [EXC_W-1:0] EXC_BP  = 5'd9;
  localparam logic [EXC_W-1:0] EXC_RI  = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV  = 5'd12;

  typedef struct packed {
    logic [IRQ_W-1:0] im;
    logic             exl;
    logic             ie;
  } status_t;

  typedef struct packed {
    logic [IRQ_W-1:0] ip;
    logic [EXC_W-1:0] exc_code;
  } cause_t;

  // Highest-priority pending exception; interrupt code when none is raised.
  function automatic logic [EXC_W-1:0] exc_code_f(input logic ri, input logic sc,
                                                  input logic bk, input logic ov);
    logic [EXC_W-1:0] code;
    if (ri)      code = EXC_RI;
    else if (sc) code = EXC_SYS;
    else if (bk) code = EXC_BP;
    else if (ov) code = EXC_OV;
    else         code = EXC_INT;
    return code;
  endfunction

  function automatic logic [XLEN-1:0] status_word(input status_t s);
    logic [XLEN-1:0] w;
    w = '0;
    w[STATUS_IE_BIT]              = s.ie;
    w[STATUS_EXL_BIT]             = s.exl;
    w[STATUS_IM_LSB +: IRQ_W]     = s.im;
    return w;
  endfunction

  function automatic logic [XLEN-1:0] cause_word(input cause_t c);
    logic [XLEN-1:0] w;
    w = '0;
    w[CAUSE_EXC_LSB +: EXC_W] = c.exc_code;
    w[CAUSE_IP_LSB +: IRQ_W]  = c.ip;
    return w;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// Register-access bus of the CP0 unit (MTC0 write and combinational read).
interface cp0_if;
  import cp0_pkg::*;

  logic [XLEN-1:0]  wr_data;
  logic [REG_W-1:0] regnum;
  logic [SEL_W-1:0] sel;
  logic             mtc0;
  logic [XLEN-1:0]  rd_data;

  modport master (output wr_data, regnum, sel, mtc0, input rd_data);
  modport slave  (input wr_data, regnum, sel, mtc0, output rd_data);
endinterface

// File: rtl/cp0_reg.sv
// Generic CP0 storage element: asynchronously reset register with load enable.
module cp0_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/cp0_unit.sv
// CP0 system-control unit: Status, Cause and EPC with exception/interrupt
// entry and ERET. Define CP0_TIMER_EN to add the Count/Compare timer.
module cp0_unit
  import cp0_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  cp0_if.slave             bus,
  input  logic [XLEN-1:0]  next_pc,
  input  logic             eret,
  input  logic [IRQ_W-1:0] interrupt_sources,
  input  logic             overflow,
  input  logic             reserved_inst,
  input  logic             syscall,
  input  logic             break_exc,
  output logic [XLEN-1:0]  epc,
  output logic             taken_handler
);

  status_t          status_q, status_d;
  cause_t           cause_q, cause_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic             status_en, epc_en;
  logic             wr_sel0, wr_status, wr_epc;
  logic [IRQ_W-1:0] irq_eff;
  logic             exc_req, int_req, taken;

  assign wr_sel0   = bus.mtc0 && (bus.sel == '0);
  assign wr_status = wr_sel0 && (bus.regnum == REG_STATUS);
  assign wr_epc    = wr_sel0 && (bus.regnum == REG_EPC);

`ifdef CP0_TIMER_EN
  logic [TIMER_W-1:0] count_q, count_d, compare_q;
  logic               timer_flag_q, wr_count, wr_compare, timer_hit;

  assign wr_count   = wr_sel0 && (bus.regnum == REG_COUNT);
  assign wr_compare = wr_sel0 && (bus.regnum == REG_COMPARE);
  assign timer_hit  = (count_q == compare_q);
  assign count_d    = wr_count ? bus.wr_data[TIMER_W-1:0] : count_q + TIMER_W'(1);

  cp0_reg #(.W(TIMER_W)) u_count (
    .clock(clock), .reset(reset), .en(1'b1), .d(count_d), .q(count_q)
  );
  cp0_reg #(.W(TIMER_W)) u_compare (
    .clock(clock), .reset(reset), .en(wr_compare), .d(bus.wr_data[TIMER_W-1:0]), .q(compare_q)
  );
  // Sticky match flag; a Compare write acknowledges it even on a coincident match.
  cp0_reg #(.W(1)) u_timer_flag (
    .clock(clock), .reset(reset), .en(wr_compare | timer_hit), .d(~wr_compare), .q(timer_flag_q)
  );

  assign irq_eff = interrupt_sources | {timer_flag_q, (IRQ_W-1)'(0)};
`else
  assign irq_eff = interrupt_sources;
`endif

  assign exc_req       = overflow | reserved_inst | syscall | break_exc;
  assign int_req       = (|(irq_eff & status_q.im)) & status_q.ie & ~status_q.exl;
  assign taken         = exc_req | int_req;
  assign taken_handler = taken;
  assign epc           = epc_q;

  // Next-state: handler entry owns EXL/EPC; MTC0 still updates IE/IM alongside it.
  always_comb begin : next_state
    status_d  = status_q;
    status_en = 1'b0;
    cause_d   = cause_q;
    epc_d     = epc_q;
    epc_en    = 1'b0;

    cause_d.ip = irq_eff;

    if (wr_status) begin
      status_d.ie  = bus.wr_data[STATUS_IE_BIT];
      status_d.exl = bus.wr_data[STATUS_EXL_BIT];
      status_d.im  = bus.wr_data[STATUS_IM_LSB +: IRQ_W];
      status_en    = 1'b1;
    end

    if (taken) begin
      status_d.exl     = 1'b1;
      status_en        = 1'b1;
      cause_d.exc_code = exc_code_f(reserved_inst, syscall, break_exc, overflow);
      epc_d            = next_pc;
      epc_en           = ~status_q.exl;
    end else begin
      if (eret) begin
        status_d.exl = 1'b0;
        status_en    = 1'b1;
      end
      if (wr_epc) begin
        epc_d  = bus.wr_data;
        epc_en = 1'b1;
      end
    end
  end

  cp0_reg #(.W($bits(status_t))) u_status (
    .clock(clock), .reset(reset), .en(status_en), .d(status_d), .q(status_q)
  );
  cp0_reg #(.W($bits(cause_t))) u_cause (
    .clock(clock), .reset(reset), .en(1'b1), .d(cause_d), .q(cause_q)
  );
  cp0_reg #(.W(XLEN)) u_epc (
    .clock(clock), .reset(reset), .en(epc_en), .d(epc_d), .q(epc_q)
  );

  always_comb begin : read_mux
    bus.rd_data = '0;
    if (bus.sel == '0) begin
      case (bus.regnum)
        REG_STATUS:  bus.rd_data = status_word(status_q);
        REG_CAUSE:   bus.rd_data = cause_word(cause_q);
        REG_EPC:     bus.rd_data = epc_q;
`ifdef CP0_TIMER_EN
        REG_COUNT:   bus.rd_data = XLEN'(count_q);
        REG_COMPARE: bus.rd_data = XLEN'(compare_q);
`endif
        default:     bus.rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed vector table, reset and timer
// sequences, then random stimulus against an architectural CP0 model.
module tb_cp0_unit;
  import cp0_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] next_pc;
  logic        eret;
  logic [7:0]  interrupt_sources;
  logic        overflow, reserved_inst, syscall, break_exc;
  logic [63:0] epc;
  logic        taken_handler;

  cp0_if bus ();

  cp0_unit dut (
    .clock(clock), .reset(reset), .bus(bus), .next_pc(next_pc), .eret(eret),
    .interrupt_sources(interrupt_sources), .overflow(overflow),
    .reserved_inst(reserved_inst), .syscall(syscall), .break_exc(break_exc),
    .epc(epc), .taken_handler(taken_handler)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        mtc0;
    logic        eret;
    logic [4:0]  regnum;
    logic [2:0]  sel;
    logic [63:0] wr;
    logic [63:0] npc;
    logic [7:0]  irq;
    logic [3:0]  exc;       // {reserved_inst, syscall, break_exc, overflow}
    logic [63:0] exp_rd;
    logic        exp_taken;
    logic [63:0] exp_epc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Architectural model state
  logic        m_ie, m_exl;
  logic [7:0]  m_im, m_ip;
  logic [4:0]  m_exc;
  logic [63:0] m_epc;
  logic [31:0] m_count, m_cmp;
  logic        m_flag;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mt, input logic er, input logic [4:0] r,
                              input logic [2:0] s, input logic [63:0] wr,
                              input logic [63:0] npc, input logic [7:0] irq,
                              input logic [3:0] exc, input logic [63:0] erd,
                              input logic etk, input logic [63:0] eepc);
    vec_t v;
    v.mtc0 = mt; v.eret = er; v.regnum = r; v.sel = s; v.wr = wr; v.npc = npc;
    v.irq = irq; v.exc = exc; v.exp_rd = erd; v.exp_taken = etk; v.exp_epc = eepc;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    bus.mtc0          = v.mtc0;
    bus.regnum        = v.regnum;
    bus.sel           = v.sel;
    bus.wr_data       = v.wr;
    eret              = v.eret;
    next_pc           = v.npc;
    interrupt_sources = v.irq;
    {reserved_inst, syscall, break_exc, overflow} = v.exc;
  endtask

  task automatic idle(input logic [4:0] r);
    apply(mk(1'b0, 1'b0, r, 3'd0, 64'h0, 64'h0, 8'h0, 4'h0, 64'h0, 1'b0, 64'h0));
  endtask

  function automatic logic [63:0] model_read(input logic [4:0] r, input logic [2:0] s);
    logic [63:0] v;
    v = 64'h0;
    if (s == 3'd0) begin
      case (r)
        5'd12: v = (64'(m_im) << 8) | (64'(m_exl) << 1) | 64'(m_ie);
        5'd13: v = (64'(m_ip) << 8) | (64'(m_exc) << 2);
        5'd14: v = m_epc;
`ifdef CP0_TIMER_EN
        5'd9:  v = 64'(m_count);
        5'd11: v = 64'(m_cmp);
`endif
        default: v = 64'h0;
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    m_ie = 1'b0; m_exl = 1'b0; m_im = 8'h0; m_ip = 8'h0; m_exc = 5'd0;
    m_epc = 64'h0; m_count = 32'h0; m_cmp = 32'h0; m_flag = 1'b0;
  endtask

  // One clock of architectural behaviour, from the pre-edge state and inputs.
  task automatic model_step(input vec_t v, input logic [7:0] eff, input logic tk);
    logic       wr_ok;
    logic [4:0] code;
    logic       hit;
    wr_ok = v.mtc0 && (v.sel == 3'd0);
    if (v.exc[3])      code = 5'd10;
    else if (v.exc[2]) code = 5'd8;
    else if (v.exc[1]) code = 5'd9;
    else if (v.exc[0]) code = 5'd12;
    else               code = 5'd0;
    hit = (m_count == m_cmp);
    if (wr_ok && v.regnum == 5'd11) begin
      m_cmp  = v.wr[31:0];
      m_flag = 1'b0;
    end else if (hit) m_flag = 1'b1;
    m_count = (wr_ok && v.regnum == 5'd9) ? v.wr[31:0] : m_count + 32'd1;
    if (tk) begin
      if (!m_exl) m_epc = v.npc;
      m_exc = code;
    end else if (wr_ok && v.regnum == 5'd14) m_epc = v.wr;
    m_ip = eff;
    if (wr_ok && v.regnum == 5'd12) begin
      m_ie = v.wr[0];
      m_im = v.wr[15:8];
    end
    if (tk)                               m_exl = 1'b1;
    else if (v.eret)                      m_exl = 1'b0;
    else if (wr_ok && v.regnum == 5'd12)  m_exl = v.wr[1];
  endtask

  initial begin
    reset = 1'b1;
    idle(5'd12);

    //        mtc0  eret  reg    sel   wr_data                npc       irq    exc      exp_rd                 tk    exp_epc
    vecs.push_back(mk(1'b1, 1'b0, 5'd11, 3'd0, 64'hFFFF_FFFF,        64'h0,    8'h00, 4'b0000, 64'h0,                 1'b0, 64'h0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'h0,                 1'b0, 64'h0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'h0,                 1'b0, 64'h0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd14, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'h0,                 1'b0, 64'h0));
    vecs.push_back(mk(1'b1, 1'b0, 5'd12, 3'd0, 64'h0000_FF01,        64'h0,    8'h00, 4'b0000, 64'h0,                 1'b0, 64'h0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 3'd0, 64'h0,                64'h400,  8'h04, 4'b0000, 64'hFF01,              1'b1, 64'h0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 3'd0, 64'h0,                64'h0,    8'h04, 4'b0000, 64'h400,               1'b0, 64'h400));
    vecs.push_back(mk(1'b0, 1'b1, 5'd12, 3'd0, 64'h0,                64'h0,    8'h04, 4'b0000, 64'hFF03,              1'b0, 64'h400));
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 3'd0, 64'h0,                64'h500,  8'h04, 4'b0000, 64'hFF01,              1'b1, 64'h400));
    vecs.push_back(mk(1'b0, 1'b1, 5'd14, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'h500,               1'b0, 64'h500));
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 3'd0, 64'h0,                64'h1000, 8'h00, 4'b1001, 64'h0,                 1'b1, 64'h500));
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'h28,                1'b0, 64'h1000));
    vecs.push_back(mk(1'b0, 1'b0, 5'd14, 3'd0, 64'h0,                64'h2000, 8'h00, 4'b0100, 64'h1000,              1'b1, 64'h1000));
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'h20,                1'b0, 64'h1000));
    vecs.push_back(mk(1'b1, 1'b0, 5'd14, 3'd0, 64'hDEAD_BEEF_0000_1234, 64'h0, 8'h00, 4'b0000, 64'h1000,              1'b0, 64'h1000));
    vecs.push_back(mk(1'b0, 1'b0, 5'd14, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'hDEAD_BEEF_0000_1234, 1'b0, 64'hDEAD_BEEF_0000_1234));
    vecs.push_back(mk(1'b1, 1'b0, 5'd13, 3'd0, '1,                   64'h0,    8'h00, 4'b0000, 64'h20,                1'b0, 64'hDEAD_BEEF_0000_1234));
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'h20,                1'b0, 64'hDEAD_BEEF_0000_1234));
    vecs.push_back(mk(1'b1, 1'b0, 5'd12, 3'd1, 64'h0,                64'h0,    8'h00, 4'b0000, 64'h0,                 1'b0, 64'hDEAD_BEEF_0000_1234));
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'hFF03,              1'b0, 64'hDEAD_BEEF_0000_1234));
    vecs.push_back(mk(1'b1, 1'b0, 5'd10, 3'd0, '1,                   64'h0,    8'h00, 4'b0000, 64'h0,                 1'b0, 64'hDEAD_BEEF_0000_1234));
    vecs.push_back(mk(1'b0, 1'b1, 5'd12, 3'd0, 64'h0,                64'h3000, 8'h00, 4'b0010, 64'hFF03,              1'b1, 64'hDEAD_BEEF_0000_1234));
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'h24,                1'b0, 64'hDEAD_BEEF_0000_1234));
    vecs.push_back(mk(1'b0, 1'b1, 5'd12, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'hFF03,              1'b0, 64'hDEAD_BEEF_0000_1234));
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'hFF01,              1'b0, 64'hDEAD_BEEF_0000_1234));
    vecs.push_back(mk(1'b1, 1'b0, 5'd12, 3'd0, 64'h0000_0F02,        64'h4000, 8'h00, 4'b0001, 64'hFF01,              1'b1, 64'hDEAD_BEEF_0000_1234));
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'h0F02,              1'b0, 64'h4000));
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'h30,                1'b0, 64'h4000));
    vecs.push_back(mk(1'b1, 1'b0, 5'd12, 3'd0, '1,                   64'h0,    8'h00, 4'b0000, 64'h0F02,              1'b0, 64'h4000));
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'hFF03,              1'b0, 64'h4000));
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 3'd0, 64'h0,                64'h0,    8'h01, 4'b0000, 64'h30,                1'b0, 64'h4000));
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 3'd0, 64'h0,                64'h0,    8'h00, 4'b0000, 64'h130,               1'b0, 64'h4000));

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      check64($sformatf("vec%0d_rd", i), bus.rd_data, vecs[i].exp_rd);
      check1($sformatf("vec%0d_taken", i), taken_handler, vecs[i].exp_taken);
      check64($sformatf("vec%0d_epc", i), epc, vecs[i].exp_epc);
      @(negedge clock);
    end

    // Reset raised mid-cycle must discard the pending handler entry.
    idle(5'd12); eret = 1'b1;
    @(negedge clock);
    idle(5'd14); interrupt_sources = 8'h01; next_pc = 64'h7000;
    #1 check1("pre_reset_taken", taken_handler, 1'b1);
    #1 reset = 1'b1;
    #1;
    check64("reset_epc", epc, 64'h0);
    check1("reset_taken", taken_handler, 1'b0);
    @(negedge clock);
    check64("reset_hold_epc", epc, 64'h0);
    check64("reset_hold_rd14", bus.rd_data, 64'h0);
    overflow = 1'b1;
    #1 check1("reset_exc_taken", taken_handler, 1'b1);
    idle(5'd12);
    @(negedge clock);
    reset = 1'b0;
    #1 check64("post_reset_status", bus.rd_data, 64'h0);

`ifdef CP0_TIMER_EN
    apply(mk(1'b1, 1'b0, 5'd11, 3'd0, 64'd5, 64'h0, 8'h0, 4'h0, 64'h0, 1'b0, 64'h0));
    bus.regnum = 5'd9;
    #1 check64("timer_count0", bus.rd_data, 64'd0);
    @(negedge clock);
    apply(mk(1'b1, 1'b0, 5'd12, 3'd0, 64'h8001, 64'h0, 8'h0, 4'h0, 64'h0, 1'b0, 64'h0));
    bus.regnum = 5'd9;
    #1 check64("timer_count1", bus.rd_data, 64'd1);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clock);
      idle(5'd9);
      #1;
      check64($sformatf("timer_count%0d", k), bus.rd_data, 64'(k));
      check1($sformatf("timer_taken%0d", k), taken_handler, k == 6);
    end
    @(negedge clock);
    idle(5'd13);
    #1 check64("timer_cause", bus.rd_data, 64'h8000);
`else
    apply(mk(1'b1, 1'b0, 5'd9, 3'd0, '1, 64'h0, 8'h0, 4'h0, 64'h0, 1'b0, 64'h0));
    #1 check64("no_timer_rd9_w", bus.rd_data, 64'h0);
    @(negedge clock);
    apply(mk(1'b1, 1'b0, 5'd11, 3'd0, '1, 64'h0, 8'h0, 4'h0, 64'h0, 1'b0, 64'h0));
    #1 check64("no_timer_rd11_w", bus.rd_data, 64'h0);
    @(negedge clock);
    idle(5'd9);
    #1 check64("no_timer_rd9", bus.rd_data, 64'h0);
    @(negedge clock);
    idle(5'd11);
    #1 check64("no_timer_rd11", bus.rd_data, 64'h0);
`endif

    // Random phase against the architectural model.
    @(negedge clock);
    idle(5'd12);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      vec_t        v;
      logic [4:0]  regs [6];
      logic [7:0]  eff;
      logic        tk;
      regs[0] = 5'd9;  regs[1] = 5'd11; regs[2] = 5'd12;
      regs[3] = 5'd13; regs[4] = 5'd14; regs[5] = 5'($urandom_range(31));
      v = mk(1'b0, 1'b0, 5'd0, 3'd0, 64'h0, 64'h0, 8'h0, 4'h0, 64'h0, 1'b0, 64'h0);
      v.mtc0   = ($urandom_range(2) == 0);
      v.eret   = ($urandom_range(7) == 0);
      v.regnum = regs[$urandom_range(5)];
      v.sel    = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'd0;
      v.wr     = {$urandom, $urandom};
      v.npc    = {$urandom, $urandom};
      v.irq    = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'h0;
      for (int b = 0; b < 4; b++) v.exc[b] = ($urandom_range(15) == 0);
      apply(v);
      #1;
      eff = v.irq | (m_flag ? 8'h80 : 8'h00);
      tk  = (|v.exc) || (((eff & m_im) != 8'h0) && m_ie && !m_exl);
      check64($sformatf("rand%0d_rd", c), bus.rd_data, model_read(v.regnum, v.sel));
      check1($sformatf("rand%0d_taken", c), taken_handler, tk);
      check64($sformatf("rand%0d_epc", c), epc, m_epc);
      model_step(v, eff, tk);
      @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
